// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between a register-window master and axi_lite_reg_slave.
// The slave modport owns the ready/response side of each channel.
interface axi_lite_reg_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8:0]   wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [RESP_WIDTH-1:0]   bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [RESP_WIDTH-1:0]   rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave for one 16-byte window: REG0/REG1 read-write, WCOUNT and SUM read-only.
// Independent write (W_IDLE/W_RESP) and read (R_IDLE/R_DATA) FSMs; bad accesses get SLVERR.
module axi_lite_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    axi_lite_reg_slave_if.slave   s_axi
);
    localparam int                    LP_NBYTES = DATA_WIDTH / 8;
    localparam logic [RESP_WIDTH-1:0] LP_OKAY   = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] LP_SLVERR = RESP_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] LP_BASE   = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    wstate_t               r_wstate;
    rstate_t               r_rstate;
    logic [DATA_WIDTH-1:0] r_reg0, r_reg1, r_wcount, r_sum;
    logic                  r_awready, r_wready, r_bvalid;
    logic [RESP_WIDTH-1:0] r_bresp;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [LP_NBYTES-1:0]  r_wstrb;
    logic                  r_arready, r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [RESP_WIDTH-1:0] r_rresp;

    logic                  w_aw_hs, w_w_hs, w_commit;
    logic [ADDR_WIDTH-1:0] w_waddr, w_woff, w_roff;
    logic [DATA_WIDTH-1:0] w_wdata, w_rsel;
    logic [LP_NBYTES-1:0]  w_wstrb;
    logic                  w_wborrow, w_rborrow, w_wok, w_rok;
    logic                  w_unused_strb;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [LP_NBYTES-1:0]  strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < LP_NBYTES; i++)
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        return res;
    endfunction

    // An already-captured channel is used from its holding register, a fresh one straight from the bus.
    assign w_aw_hs  = s_axi.awvalid && r_awready;
    assign w_w_hs   = s_axi.wvalid && r_wready;
    assign w_commit = (r_wstate == W_IDLE) && (w_aw_hs || !r_awready) && (w_w_hs || !r_wready);
    assign w_waddr  = r_awready ? s_axi.awaddr : r_awaddr;
    assign w_wdata  = r_wready ? s_axi.wdata : r_wdata;
    assign w_wstrb  = r_wready ? s_axi.wstrb[LP_NBYTES-1:0] : r_wstrb;
    assign w_unused_strb = s_axi.wstrb[LP_NBYTES];

    assign {w_wborrow, w_woff} = {1'b0, w_waddr} - {1'b0, LP_BASE};
    assign {w_rborrow, w_roff} = {1'b0, s_axi.araddr} - {1'b0, LP_BASE};
    assign w_wok = !w_wborrow && (w_woff[ADDR_WIDTH-1:4] == '0) && (w_woff[1:0] == 2'b00) && !w_woff[3];
    assign w_rok = !w_rborrow && (w_roff[ADDR_WIDTH-1:4] == '0) && (w_roff[1:0] == 2'b00);

    always_comb begin
        w_rsel = '0;  // NOTE: default assignment first so no path leaves w_rsel unassigned (no latch).
        case (w_roff[3:2])
            2'd0:    w_rsel = r_reg0;
            2'd1:    w_rsel = r_reg1;
            2'd2:    w_rsel = r_wcount;
            default: w_rsel = r_sum;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wstate  <= W_IDLE;
            r_reg0    <= '0;
            r_reg1    <= '0;
            r_wcount  <= '0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= LP_OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            // NOTE: non-blocking updates so every read of r_* in this cycle sees the pre-edge value.
            case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_wstate  <= W_RESP;
                        if (w_wok) begin
                            r_bresp  <= LP_OKAY;
                            r_wcount <= r_wcount + DATA_WIDTH'(1);
                            if (!w_woff[2]) r_reg0 <= merge_bytes(r_reg0, w_wdata, w_wstrb);
                            else            r_reg1 <= merge_bytes(r_reg1, w_wdata, w_wstrb);
                        end else begin
                            r_bresp <= LP_SLVERR;
                        end
                    end else begin
                        if (w_aw_hs) begin
                            r_awready <= 1'b0;
                            r_awaddr  <= s_axi.awaddr;
                        end
                        if (w_w_hs) begin
                            r_wready <= 1'b0;
                            r_wdata  <= s_axi.wdata;
                            r_wstrb  <= s_axi.wstrb[LP_NBYTES-1:0];
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) r_sum <= '0;
        else                r_sum <= r_reg0 + r_reg1;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= LP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s_axi.arvalid) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rstate  <= R_DATA;
                        r_rdata   <= w_rok ? w_rsel : '0;
                        r_rresp   <= w_rok ? LP_OKAY : LP_SLVERR;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;
endmodule
